// File: rtl/reg_pkg.sv
// Register-file shared constants and the dump sequencer state type.
// Imported by the register file and by reg_dump_reader.
package reg_pkg;

    localparam int REG_W = 8;
    localparam int REG_D = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks a wrapping register range on read port A and streams (addr, data)
// beats out over valid/ready. Ports: Clk/Reset_n, Start/Abort/FirstAddr/
// LastAddr control, RaddrA/DataOutA read port, Str* stream, Busy/Done status.
module reg_dump_reader
    import reg_pkg::*;
#(
    parameter int W = REG_W,
    parameter int D = REG_D
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         Abort,
    input  logic [D-1:0] FirstAddr,
    input  logic [D-1:0] LastAddr,
    output logic [D-1:0] RaddrA,
    input  logic [W-1:0] DataOutA,
    output logic         StrValid,
    input  logic         StrReady,
    output logic [D-1:0] StrAddr,
    output logic [W-1:0] StrData,
    output logic         Busy,
    output logic         Done
);

    localparam logic [D-1:0] PTR_ONE = D'(1);

    dump_state_t  state_q, state_d;
    logic [D-1:0] ptr_q, ptr_d;
    logic [D-1:0] last_q, last_d;
    logic         vld_d, busy_d, done_d;
    logic [D-1:0] addr_d;
    logic [W-1:0] data_d;
    logic         ld;
    logic         hs;

    assign RaddrA = ptr_q;

    // The output register refills whenever it is empty or being drained,
    // so StrReady only reaches the register enables, never the outputs.
    assign ld = (state_q == RUN) && (!StrValid || StrReady);
    assign hs = StrValid && StrReady;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            last_q   <= '0;
            StrValid <= 1'b0;
            StrAddr  <= '0;
            StrData  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            last_q   <= last_d;
            StrValid <= vld_d;
            StrAddr  <= addr_d;
            StrData  <= data_d;
            Busy     <= busy_d;
            Done     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        vld_d   = StrValid;
        addr_d  = StrAddr;
        data_d  = StrData;
        busy_d  = Busy;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start && !Abort) begin
                    ptr_d   = FirstAddr;
                    last_d  = LastAddr;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (Abort) begin
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (ld) begin
                    data_d = DataOutA;
                    addr_d = ptr_q;
                    vld_d  = 1'b1;
                    if (ptr_q == last_q) begin
                        state_d = DRAIN;
                    end else begin
                        ptr_d = ptr_q + PTR_ONE;
                    end
                end
            end
            DRAIN: begin
                if (Abort) begin
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (hs) begin
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                vld_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a behavioural register file.
// Beats are collected on handshake and compared against hand-computed order.
module tb_reg_dump_reader;
    import reg_pkg::*;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic             Start = 1'b0;
    logic             Abort = 1'b0;
    logic [REG_D-1:0] FirstAddr = '0;
    logic [REG_D-1:0] LastAddr = '0;
    logic [REG_D-1:0] RaddrA;
    logic [REG_W-1:0] DataOutA;
    logic             StrValid;
    logic             StrReady = 1'b1;
    logic [REG_D-1:0] StrAddr;
    logic [REG_W-1:0] StrData;
    logic             Busy;
    logic             Done;

    logic [REG_W-1:0] regs [16];
    logic             rf_init = 1'b1;
    logic             we = 1'b0;
    logic [REG_D-1:0] wa = '0;
    logic [REG_W-1:0] wd = '0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit hs_this = 1'b0;
    logic [11:0] beats [$];

    reg_dump_reader #(.W(REG_W), .D(REG_D)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
        .FirstAddr(FirstAddr), .LastAddr(LastAddr),
        .RaddrA(RaddrA), .DataOutA(DataOutA),
        .StrValid(StrValid), .StrReady(StrReady),
        .StrAddr(StrAddr), .StrData(StrData),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    assign DataOutA = regs[RaddrA];

    always @(posedge Clk) begin
        if (rf_init) begin
            for (int i = 0; i < 16; i++) regs[i] <= 8'h10 + 8'(i);
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: record a handshake, advance, check held beats stayed put.
    task automatic step();
        logic held;
        logic [REG_D-1:0] ha;
        logic [REG_W-1:0] hd;
        held = StrValid && !StrReady && !Abort;
        ha = StrAddr;
        hd = StrData;
        hs_this = StrValid && StrReady;
        if (hs_this) beats.push_back({StrAddr, StrData});
        @(posedge Clk);
        #1;
        if (held) begin
            chk("hold_vld", 32'(StrValid), 32'd1);
            chk("hold_addr", 32'(StrAddr), 32'(ha));
            chk("hold_data", 32'(StrData), 32'(hd));
        end
        if (Done) done_cnt++;
    endtask

    task automatic start_dump(input logic [3:0] f, input logic [3:0] l);
        beats.delete();
        done_cnt = 0;
        FirstAddr = f;
        LastAddr = l;
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0 repeating
    task automatic run_collect(input int mode, input int nexp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            StrReady = (mode == 0) ? 1'b1 : (i % 3 == 0);
            step();
            if (Done) begin
                seen = 1'b1;
                chk("done_on_last_hs", 32'(hs_this), 32'd1);
                chk("busy_at_done", 32'(Busy), 32'd0);
                chk("nbeats_at_done", 32'(beats.size()), 32'(nexp));
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        StrReady = 1'b1;
        step();
        step();
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("idle_vld", 32'(StrValid), 32'd0);
    endtask

    task automatic check_beats(input logic [3:0] f, input int n);
        logic [3:0] a;
        chk("nbeats", 32'(beats.size()), 32'(n));
        for (int i = 0; i < n && i < beats.size(); i++) begin
            a = f + 4'(i);
            chk("beat_addr", 32'(beats[i][11:8]), 32'(a));
            chk("beat_data", 32'(beats[i][7:0]), 32'(8'h10 + 8'(a)));
        end
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_vld", 32'(StrValid), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_addr", 32'(StrAddr), 32'd0);
        chk("rst_data", 32'(StrData), 32'd0);
        chk("rst_raddr", 32'(RaddrA), 32'd0);
        #3 Reset_n = 1'b1;
        rf_init = 1'b0;
        step();

        // basic 2..5, first beat one cycle after Start accepted
        start_dump(4'd2, 4'd5);
        chk("busy_on_start", 32'(Busy), 32'd1);
        step();
        chk("first_vld", 32'(StrValid), 32'd1);
        chk("first_addr", 32'(StrAddr), 32'd2);
        chk("first_data", 32'(StrData), 32'h12);
        run_collect(0, 4);
        check_beats(4'd2, 4);

        // wrap 14..1 and full range 7..6
        start_dump(4'd14, 4'd1);
        run_collect(0, 4);
        check_beats(4'd14, 4);
        start_dump(4'd7, 4'd6);
        run_collect(0, 16);
        check_beats(4'd7, 16);

        // backpressure
        start_dump(4'd0, 4'd3);
        run_collect(1, 4);
        check_beats(4'd0, 4);

        // Start together with Abort is dropped
        FirstAddr = 4'd1;
        LastAddr = 4'd2;
        Start = 1'b1;
        Abort = 1'b1;
        step();
        Start = 1'b0;
        Abort = 1'b0;
        chk("startabort_busy", 32'(Busy), 32'd0);
        step();
        chk("startabort_vld", 32'(StrValid), 32'd0);

        // abort on second beat while stalled
        StrReady = 1'b0;
        start_dump(4'd0, 4'd5);
        step();
        chk("ab_beat1", 32'(StrAddr), 32'd0);
        StrReady = 1'b1;
        step();
        chk("ab_beat2_vld", 32'(StrValid), 32'd1);
        chk("ab_beat2", 32'(StrAddr), 32'd1);
        StrReady = 1'b0;
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        chk("ab_vld", 32'(StrValid), 32'd0);
        chk("ab_busy", 32'(Busy), 32'd0);
        StrReady = 1'b1;
        repeat (4) step();
        chk("ab_nodone", 32'(done_cnt), 32'd0);
        start_dump(4'd9, 4'd9);
        run_collect(0, 1);
        check_beats(4'd9, 1);

        // asynchronous reset mid-dump
        start_dump(4'd0, 4'd15);
        step();
        step();
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_vld", 32'(StrValid), 32'd0);
        chk("arst_busy", 32'(Busy), 32'd0);
        chk("arst_addr", 32'(StrAddr), 32'd0);
        chk("arst_data", 32'(StrData), 32'd0);
        chk("arst_raddr", 32'(RaddrA), 32'd0);
        #3 Reset_n = 1'b1;
        repeat (4) step();
        chk("arst_noresume", 32'(StrValid), 32'd0);
        chk("arst_idle", 32'(Busy), 32'd0);
        chk("arst_nodone", 32'(done_cnt), 32'd0);

        // Start while busy is ignored
        StrReady = 1'b0;
        start_dump(4'd0, 4'd3);
        step();
        FirstAddr = 4'd8;
        LastAddr = 4'd8;
        Start = 1'b1;
        step();
        Start = 1'b0;
        run_collect(0, 4);
        check_beats(4'd0, 4);

        // same-edge write is not seen
        start_dump(4'd2, 4'd5);
        step();
        we = 1'b1;
        wa = 4'd3;
        wd = 8'hAA;
        step();
        we = 1'b0;
        run_collect(0, 4);
        chk("coh_same_edge", 32'(beats[1][7:0]), 32'h13);
        wa = 4'd3;
        wd = 8'h13;
        we = 1'b1;
        step();
        we = 1'b0;

        // earlier write to a pending register is seen
        start_dump(4'd2, 4'd5);
        step();
        we = 1'b1;
        wa = 4'd4;
        wd = 8'hBB;
        step();
        we = 1'b0;
        run_collect(0, 4);
        chk("coh_early", 32'(beats[2][7:0]), 32'hBB);
        chk("coh_other", 32'(beats[3][7:0]), 32'h15);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
